// File: rtl/food_sprite_painter.sv
// Paints a PIXELS_WIDTH x PIXELS_WIDTH sprite: fg inside a circle (dist^2 < radius_sq), bg outside.
// Latency: first write presented the cycle after start; one pixel per accepted write, done one cycle after the last write.
// Backpressure: wr_ready low holds wr_x/wr_y/wr_data/wr_en stable; scan resumes without bubbles once wr_ready returns.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start                           paint request, honoured only in IDLE
//   center_x/_y, radius_sq          circle geometry, latched at start
//   fg_color, bg_color              inside/outside colours, latched at start
//   wr_ready                        sprite memory accepts the current write
//   wr_en, wr_x, wr_y, wr_data      registered write request (y is the fast index)
//   busy, done                      sprite in progress / one-cycle completion pulse
module food_sprite_painter #(
    parameter int PIXELS_WIDTH     = 80,
    parameter int REL_BITS         = 7,
    parameter int PIXEL_COLOR_BITS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [REL_BITS-1:0]         center_x,
    input  logic [REL_BITS-1:0]         center_y,
    input  logic [15:0]                 radius_sq,
    input  logic [PIXEL_COLOR_BITS-1:0] fg_color,
    input  logic [PIXEL_COLOR_BITS-1:0] bg_color,
    input  logic                        wr_ready,
    output logic                        wr_en,
    output logic [REL_BITS-1:0]         wr_x,
    output logic [REL_BITS-1:0]         wr_y,
    output logic [PIXEL_COLOR_BITS-1:0] wr_data,
    output logic                        busy,
    output logic                        done
);

    // Sum width: at least 2*REL_BITS+3, and always wider than radius_sq so the compare is lossless.
    localparam int SUM_W  = (2 * REL_BITS + 3 > 16) ? 2 * REL_BITS + 3 : 17;
    localparam int PROD_W = 2 * REL_BITS + 2;
    localparam logic [REL_BITS-1:0] LAST = REL_BITS'(PIXELS_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAINT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [REL_BITS-1:0]           x_q, x_d;
    logic [REL_BITS-1:0]           y_q, y_d;
    logic [PIXEL_COLOR_BITS-1:0]   data_q, data_d;
    logic                          wr_en_q, wr_en_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic [REL_BITS-1:0]           cx_q, cx_d;
    logic [REL_BITS-1:0]           cy_q, cy_d;
    logic [15:0]                   rsq_q, rsq_d;
    logic [PIXEL_COLOR_BITS-1:0]   fg_q, fg_d;
    logic [PIXEL_COLOR_BITS-1:0]   bg_q, bg_d;
    logic [REL_BITS-1:0]           nx, ny;

    // Offsets are formed one bit wider and signed so a centre near either edge
    // yields the true negative offset; squares are taken after sign extension
    // to a width that cannot overflow.
    function automatic logic [PIXEL_COLOR_BITS-1:0] pixel_color(
        input logic [REL_BITS-1:0]         px,
        input logic [REL_BITS-1:0]         py,
        input logic [REL_BITS-1:0]         cx,
        input logic [REL_BITS-1:0]         cy,
        input logic [15:0]                 rsq,
        input logic [PIXEL_COLOR_BITS-1:0] fg,
        input logic [PIXEL_COLOR_BITS-1:0] bg
    );
        logic signed [REL_BITS:0]   dx;
        logic signed [REL_BITS:0]   dy;
        logic signed [PROD_W-1:0]   dxe;
        logic signed [PROD_W-1:0]   dye;
        logic [SUM_W-1:0]           sum;
        dx  = $signed({1'b0, px}) - $signed({1'b0, cx});
        dy  = $signed({1'b0, py}) - $signed({1'b0, cy});
        dxe = {{(REL_BITS + 1){dx[REL_BITS]}}, dx};
        dye = {{(REL_BITS + 1){dy[REL_BITS]}}, dy};
        sum = SUM_W'($unsigned(dxe * dxe)) + SUM_W'($unsigned(dye * dye));
        return (sum < {{(SUM_W - 16){1'b0}}, rsq}) ? fg : bg;
    endfunction

    // Next scan coordinate, y fastest.
    always_comb begin
        nx = x_q;
        ny = y_q + 1'b1;
        if (y_q == LAST) begin
            ny = '0;
            nx = x_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        data_d  = data_q;
        wr_en_d = wr_en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cx_d    = cx_q;
        cy_d    = cy_q;
        rsq_d   = rsq_q;
        fg_d    = fg_q;
        bg_d    = bg_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cx_d    = center_x;
                    cy_d    = center_y;
                    rsq_d   = radius_sq;
                    fg_d    = fg_color;
                    bg_d    = bg_color;
                    x_d     = '0;
                    y_d     = '0;
                    // Params are not latched yet, so colour (0,0) from the live inputs.
                    data_d  = pixel_color('0, '0, center_x, center_y, radius_sq,
                                          fg_color, bg_color);
                    wr_en_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = PAINT;
                end
            end
            PAINT: begin
                if (wr_ready) begin
                    if (x_q == LAST && y_q == LAST) begin
                        wr_en_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        x_d    = nx;
                        y_d    = ny;
                        data_d = pixel_color(nx, ny, cx_q, cy_q, rsq_q, fg_q, bg_q);
                    end
                end
            end
            DONE: begin
                // start is deliberately ignored here; a new sprite begins only from IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                wr_en_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            rsq_q   <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            data_q  <= data_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            rsq_q   <= rsq_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_x    = x_q;
    assign wr_y    = y_q;
    assign wr_data = data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_food_sprite_painter.sv
module tb_food_sprite_painter;

    localparam int PW = 80;
    localparam int NPIX = PW * PW;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [6:0] center_x, center_y;
    logic [15:0] radius_sq;
    logic [7:0] fg_color, bg_color;
    logic       wr_ready;
    logic       wr_en;
    logic [6:0] wr_x, wr_y;
    logic [7:0] wr_data;
    logic       busy, done;

    food_sprite_painter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .center_x (center_x),
        .center_y (center_y),
        .radius_sq(radius_sq),
        .fg_color (fg_color),
        .bg_color (bg_color),
        .wr_ready (wr_ready),
        .wr_en    (wr_en),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] pix [NPIX];
    int done_cyc, nwr, order_err, stall_err, stalls, aborted;
    int f_en, f_busy, f_x, f_y, f_dat;
    int post_done, post_busy, post_en;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    function automatic int model_px(input int x, y, cx, cy, rsq, fg, bg);
        int dx, dy;
        dx = x - cx;
        dy = y - cy;
        return (dx * dx + dy * dy < rsq) ? fg : bg;
    endfunction

    function automatic int map_errors(input int cx, cy, rsq, fg, bg);
        int e;
        e = 0;
        for (int x = 0; x < PW; x++)
            for (int y = 0; y < PW; y++)
                if (pix[x * PW + y] !== 8'(model_px(x, y, cx, cy, rsq, fg, bg))) e++;
        return e;
    endfunction

    function automatic int count_val(input int v);
        int c;
        c = 0;
        for (int i = 0; i < NPIX; i++) if (pix[i] === 8'(v)) c++;
        return c;
    endfunction

    // Drives one sprite. Optional alternating stalls, a mid-sprite start with
    // altered inputs at write mid_at, and a reset just before write abort_at.
    task automatic run_sprite(input int cx, cy, rsq, fg, bg,
                              input bit stall, input int mid_at, input int abort_at);
        int cyc, ex, ey, idx;
        bit held;
        logic [6:0] hx, hy;
        logic [7:0] hd;
        nwr = 0; order_err = 0; stall_err = 0; stalls = 0; done_cyc = 0; aborted = 0;
        ex = 0; ey = 0; held = 0; hx = '0; hy = '0; hd = '0;
        for (int i = 0; i < NPIX; i++) pix[i] = 'x;
        @(negedge clk);
        center_x = 7'(cx); center_y = 7'(cy); radius_sq = 16'(rsq);
        fg_color = 8'(fg); bg_color = 8'(bg); wr_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        f_en = int'(wr_en); f_busy = int'(busy); f_x = int'(wr_x); f_y = int'(wr_y); f_dat = int'(wr_data);
        while (cyc < 20000) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (held && (wr_en !== 1'b1 || wr_x !== hx || wr_y !== hy || wr_data !== hd)) stall_err++;
            held = 0;
            wr_ready = stall ? (cyc % 2 == 1) : 1'b1;
            if (wr_en === 1'b1) begin
                if (wr_ready) begin
                    if (int'(wr_x) != ex || int'(wr_y) != ey) order_err++;
                    idx = int'(wr_x) * PW + int'(wr_y);
                    if (idx < NPIX) pix[idx] = wr_data;
                    nwr++;
                    if (ey == PW - 1) begin ey = 0; ex++; end
                    else ey++;
                    if (nwr == mid_at) begin
                        start = 1'b1; fg_color = 8'h11; bg_color = 8'h22;
                        center_x = 7'd0; center_y = 7'd0; radius_sq = 16'hFFFF;
                    end
                    if (nwr == abort_at) begin
                        #2 rst_n = 1'b0;
                        #1 aborted = 1;
                        break;
                    end
                end else begin
                    held = 1; hx = wr_x; hy = wr_y; hd = wr_data; stalls++;
                end
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        if (!aborted && done_cyc != 0) begin
            // start during the done cycle must be ignored
            start = 1'b1; wr_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            post_done = int'(done); post_busy = int'(busy); post_en = int'(wr_en);
        end
    endtask

    int hits;

    initial begin
        rst_n = 1'b0; start = 1'b0; wr_ready = 1'b1;
        center_x = '0; center_y = '0; radius_sq = '0; fg_color = '0; bg_color = '0;
        #12;
        check_eq("rst_wr_en", int'(wr_en), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_wr_x", int'(wr_x), 0);
        check_eq("rst_wr_y", int'(wr_y), 0);
        check_eq("rst_wr_data", int'(wr_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_no_write", int'(wr_en), 0);

        // Basic circle, no backpressure
        run_sprite(40, 40, 225, 'hFF, 'h00, 0, -1, -1);
        check_eq("t1_first_en", f_en, 1);
        check_eq("t1_first_busy", f_busy, 1);
        check_eq("t1_first_x", f_x, 0);
        check_eq("t1_first_y", f_y, 0);
        check_eq("t1_first_data", f_dat, 'h00);
        check_eq("t1_done_cycle", done_cyc, 6401);
        check_eq("t1_writes", nwr, NPIX);
        check_eq("t1_order_err", order_err, 0);
        check_eq("t1_map_err", map_errors(40, 40, 225, 'hFF, 'h00), 0);
        check_eq("t1_px_40_40", int'(pix[40 * PW + 40]), 'hFF);
        check_eq("t1_px_40_54", int'(pix[40 * PW + 54]), 'hFF);
        check_eq("t1_px_40_55", int'(pix[40 * PW + 55]), 'h00);
        check_eq("t1_px_0_0", int'(pix[0]), 'h00);
        check_eq("t1_done_one_cycle", post_done, 0);
        check_eq("t1_start_at_done_busy", post_busy, 0);
        check_eq("t1_start_at_done_en", post_en, 0);

        // Same sprite with alternating wr_ready
        run_sprite(40, 40, 225, 'hFF, 'h00, 1, -1, -1);
        check_eq("t2_writes", nwr, NPIX);
        check_eq("t2_order_err", order_err, 0);
        check_eq("t2_stable_err", stall_err, 0);
        check_eq("t2_stall_seen", int'(stalls > 6000), 1);
        check_eq("t2_done_cycle", done_cyc, 6401 + stalls);
        check_eq("t2_map_err", map_errors(40, 40, 225, 'hFF, 'h00), 0);

        // Corner centre, tiny radius
        run_sprite(0, 0, 4, 'hFF, 'h00, 0, -1, -1);
        check_eq("t3_map_err", map_errors(0, 0, 4, 'hFF, 'h00), 0);
        check_eq("t3_fg_count", count_val('hFF), 4);
        check_eq("t3_px_1_1", int'(pix[1 * PW + 1]), 'hFF);
        check_eq("t3_px_2_0", int'(pix[2 * PW + 0]), 'h00);
        check_eq("t3_px_0_2", int'(pix[0 * PW + 2]), 'h00);

        // Zero radius: all background
        run_sprite(40, 40, 0, 'hAA, 'h55, 0, -1, -1);
        check_eq("t4_bg_count", count_val('h55), NPIX);
        check_eq("t4_done_cycle", done_cyc, 6401);

        // Edge centre; start and parameter changes mid-sprite are ignored
        run_sprite(79, 0, 900, 'hC3, 'h3C, 0, 50, -1);
        check_eq("t5_done_cycle", done_cyc, 6401);
        check_eq("t5_writes", nwr, NPIX);
        check_eq("t5_map_err", map_errors(79, 0, 900, 'hC3, 'h3C), 0);
        check_eq("t5_px_79_0", int'(pix[79 * PW + 0]), 'hC3);
        check_eq("t5_px_0_79", int'(pix[0 * PW + 79]), 'h3C);
        check_eq("t5_done_one_cycle", post_done, 0);

        // Reset at write 100 aborts; then a fresh sprite
        run_sprite(40, 40, 225, 'hFF, 'h00, 0, -1, 100);
        check_eq("t6_aborted", aborted, 1);
        check_eq("t6_async_wr_en", int'(wr_en), 0);
        check_eq("t6_async_busy", int'(busy), 0);
        check_eq("t6_async_wr_y", int'(wr_y), 0);
        hits = 0;
        repeat (2) begin
            @(negedge clk);
            if (wr_en !== 1'b0 || done !== 1'b0) hits++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) hits++;
        end
        check_eq("t6_no_activity_after_abort", hits, 0);
        run_sprite(79, 79, 50, 'h5A, 'hA5, 0, -1, -1);
        check_eq("t7_first_x", f_x, 0);
        check_eq("t7_first_y", f_y, 0);
        check_eq("t7_order_err", order_err, 0);
        check_eq("t7_done_cycle", done_cyc, 6401);
        check_eq("t7_map_err", map_errors(79, 79, 50, 'h5A, 'hA5), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/food_sprite_painter.md
FOOD_SPRITE_PAINTER -- requirements
Module: food_sprite_painter

Interface
REQ-001 Parameter PIXELS_WIDTH, default 80: sprite edge length in pixels; the sprite is PIXELS_WIDTH x PIXELS_WIDTH.
REQ-002 Parameter REL_BITS, default 7: width of relative x/y coordinates; 2^REL_BITS SHALL be >= PIXELS_WIDTH.
REQ-003 Parameter PIXEL_COLOR_BITS, default 8: pixel colour width.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request to paint one full sprite.
REQ-007 center_x, center_y  input  REL_BITS each  circle centre, unsigned, sampled at start.
REQ-008 radius_sq  input  16  squared radius, unsigned, sampled at start.
REQ-009 fg_color, bg_color  input  PIXEL_COLOR_BITS each  inside/outside colours, sampled at start.
REQ-010 wr_ready  input  1  sprite memory accepts the current write this cycle.
REQ-011 wr_en  output  1  write request valid.
REQ-012 wr_x, wr_y  output  REL_BITS each  relative pixel address of the current write.
REQ-013 wr_data  output  PIXEL_COLOR_BITS  colour of the current write.
REQ-014 busy  output  1  high from sprite start until the last write is accepted.
REQ-015 done  output  1  single-cycle completion pulse.

Function
REQ-016 States: IDLE, PAINT, DONE; all outputs SHALL be registered.
REQ-017 IDLE: when start=1 at a clock edge, latch center_x, center_y, radius_sq, fg_color and bg_color, load x=0 and y=0, and enter PAINT; after that edge busy=1, wr_en=1, wr_x=0, wr_y=0, and wr_data is valid for (0,0).
REQ-018 Colour rule: dx = x - center_x and dy = y - center_y, both signed REL_BITS+1 bits.
REQ-019 Sum = dx*dx + dy*dy, computed at least 2*REL_BITS+3 bits wide with no truncation.
REQ-020 Pixel colour SHALL be fg_color if sum < radius_sq (strict) and bg_color otherwise.
REQ-021 Handshake: a write transfers on a clock edge where wr_en=1 and wr_ready=1.
REQ-022 While wr_en=1 and wr_ready=0, wr_x, wr_y and wr_data SHALL hold stable.
REQ-023 Scan order: y is the fast index. After a transfer with y < PIXELS_WIDTH-1, y increments; with y = PIXELS_WIDTH-1, y wraps to 0 and x increments.
REQ-024 wr_data for the next coordinate SHALL be presented on the same edge that accepts the current write, so there are no bubbles when wr_ready is held high.
REQ-025 Transfer of (PIXELS_WIDTH-1, PIXELS_WIDTH-1) SHALL enter DONE: wr_en=0, busy=0, done=1 for exactly one cycle, then IDLE.
REQ-026 With wr_ready held at 1, done SHALL assert exactly PIXELS_WIDTH*PIXELS_WIDTH+1 cycles after the start edge.
REQ-027 start while in PAINT or DONE SHALL be ignored, and the latched parameters SHALL NOT change.
REQ-028 start in the same cycle that done=1 SHALL be ignored; a new sprite begins only from IDLE.
REQ-029 Parameter inputs changing during PAINT SHALL NOT affect the sprite in progress.
REQ-030 radius_sq=0 SHALL paint every pixel bg_color.
REQ-031 A centre at or near the sprite edge SHALL be handled correctly by the signed arithmetic, without wrap-around error.
REQ-032 wr_x and wr_y SHALL never exceed PIXELS_WIDTH-1.

Reset
REQ-033 rst_n=0 SHALL immediately, without waiting for a clock edge, force state IDLE, wr_en=0, busy=0, done=0, wr_x=0, wr_y=0 and wr_data=0.
REQ-034 rst_n=0 SHALL clear all latched parameters to 0.
REQ-035 Reset during PAINT SHALL abort the sprite with no further writes, and no done pulse SHALL follow.
REQ-036 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-037 Default parameters, center (40,40), radius_sq=225, fg=8'hFF, bg=8'h00, wr_ready=1 -> 6400 writes in order; (40,40)=FF, (40,54)=FF, (40,55)=00, (0,0)=00; done at cycle 6401.
REQ-038 Same as REQ-037 but wr_ready toggles 1,0,1,0 -> no write lost or duplicated, outputs stable while stalled, identical pixel map, done delayed by the number of stall cycles.
REQ-039 center (0,0), radius_sq=4 -> FF exactly at (0,0), (0,1), (1,0), (1,1); all other pixels 00.
REQ-040 radius_sq=0 -> all 6400 pixels equal bg_color.
REQ-041 start pulsed again mid-sprite with different colours -> ignored; the sprite completes with the original colours; one done pulse.
REQ-042 rst_n low at write 100 -> wr_en and busy drop asynchronously, no done; a fresh start repaints from (0,0).
